// File: rtl/scan_test_pkg.sv
// Shared types and helpers for the scan-test sequencer: FSM state encoding and
// the per-vector mismatch rule.
package scan_test_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SHIFT,
    S_CAPTURE,
    S_CHECK,
    S_FLUSH,
    S_FCHECK,
    S_DONE
  } state_t;

  // The CUT state unloaded before the first vector is left over from whatever ran
  // earlier, so only the primary outputs are meaningful for that vector.
  function automatic logic vec_mismatch(input logic first_vec,
                                        input logic st_differs,
                                        input logic po_differs);
    return po_differs | (~first_vec & st_differs);
  endfunction

endpackage

// File: rtl/scan_test_ctrl_if.sv
// Vector stream from the pattern source (ROM/FIFO) into the scan-test sequencer.
interface scan_test_ctrl_if #(
  parameter int PI_W = 17,
  parameter int ST_W = 56,
  parameter int PO_W = 27
) ();

  // A vector moves on a rising edge where vec_valid && vec_ready are both high.
  // The source keeps the payload stable while vec_valid && !vec_ready. vec_ready
  // does not depend on vec_valid.
  logic            vec_valid;
  logic            vec_ready;
  logic            vec_last;
  logic [PI_W-1:0] vec_pi;
  logic [ST_W-1:0] vec_scan;
  logic [ST_W-1:0] vec_exp_st;
  logic [PO_W-1:0] vec_exp_po;

  modport master (
    output vec_valid, vec_last, vec_pi, vec_scan, vec_exp_st, vec_exp_po,
    input  vec_ready
  );

  modport slave (
    input  vec_valid, vec_last, vec_pi, vec_scan, vec_exp_st, vec_exp_po,
    output vec_ready
  );

endinterface

// File: rtl/scan_capture_chain.sv
// One scan chain's shadow register: loads the scan-in pattern, shifts it out LSB
// first on si while collecting so into the top, so bit k ends up holding so of shift cycle k.
module scan_capture_chain #(
  parameter int CHAIN_LEN = 28
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [CHAIN_LEN-1:0] load_val,
  input  logic                 shift,
  input  logic                 so,
  output logic                 si,
  output logic [CHAIN_LEN-1:0] captured
);

  logic [CHAIN_LEN-1:0] sr_q;
  logic [CHAIN_LEN-1:0] sr_d;
  logic [CHAIN_LEN-1:0] shifted;

  generate
    if (CHAIN_LEN == 1) begin : g_single
      assign shifted = so;
    end else begin : g_multi
      assign shifted = {so, sr_q[CHAIN_LEN-1:1]};
    end
  endgenerate

  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = load_val;
    end else if (shift) begin
      sr_d = shifted;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign si       = sr_q[0];
  assign captured = sr_q;

endmodule

// File: rtl/scan_test_ctrl.sv
// Scan-test sequencer: fetches stored vectors, shifts them into NUM_CHAINS parallel
// chains of the CUT, pulses capture, and compares unloaded state and POs with expectations.
module scan_test_ctrl
  import scan_test_pkg::*;
#(
  parameter int CHAIN_LEN  = 28,
  parameter int NUM_CHAINS = 2,
  parameter int PI_W       = 17,
  parameter int PO_W       = 27,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop_on_fail,
  scan_test_ctrl_if.slave       vec,
  output logic [PI_W-1:0]       dut_pi,
  output logic                  dut_nbar_t,
  output logic [NUM_CHAINS-1:0] dut_si,
  input  logic [NUM_CHAINS-1:0] dut_so,
  input  logic [PO_W-1:0]       dut_po,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [CNT_W-1:0]      fail_count,
  output logic [CNT_W-1:0]      vec_count,
  output logic [CNT_W-1:0]      first_fail_idx,
  output state_t                dbg_state
);

  localparam int ST_W = CHAIN_LEN * NUM_CHAINS;
  localparam int SC_W = $clog2(CHAIN_LEN + 1);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(CHAIN_LEN - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t            state_q, state_d;
  logic [SC_W-1:0]   sc_q, sc_d;
  logic              stop_mode_q, stop_mode_d;
  logic              first_vec_q, first_vec_d;
  logic [PI_W-1:0]   pi_q, pi_d;
  logic [ST_W-1:0]   exp_st_q, exp_st_d;
  logic [ST_W-1:0]   prev_st_q, prev_st_d;
  logic [PO_W-1:0]   exp_po_q, exp_po_d;
  logic              last_q, last_d;
  logic [PO_W-1:0]   po_q, po_d;
  logic              fail_q, fail_d;
  logic [CNT_W-1:0]  fail_count_q, fail_count_d;
  logic [CNT_W-1:0]  vec_count_q, vec_count_d;
  logic [CNT_W-1:0]  ffi_q, ffi_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ready_q, ready_d;
  logic              nbar_q, nbar_d;
  logic              si_en_q, si_en_d;

  logic              accept;
  logic              load;
  logic              shift;
  logic              st_differs;
  logic              mismatch;
  logic [ST_W-1:0]   captured;
  logic [NUM_CHAINS-1:0] chain_si;

  assign accept = (state_q == S_FETCH) && ready_q && vec.vec_valid;
  assign shift  = (state_q == S_SHIFT) || (state_q == S_FLUSH);

  for (genvar c = 0; c < NUM_CHAINS; c++) begin : g_chain
    scan_capture_chain #(.CHAIN_LEN(CHAIN_LEN)) u_chain (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .load_val (vec.vec_scan[c*CHAIN_LEN +: CHAIN_LEN]),
      .shift    (shift),
      .so       (dut_so[c]),
      .si       (chain_si[c]),
      .captured (captured[c*CHAIN_LEN +: CHAIN_LEN])
    );
  end

  always_comb begin
    state_d      = state_q;
    sc_d         = sc_q;
    stop_mode_d  = stop_mode_q;
    first_vec_d  = first_vec_q;
    pi_d         = pi_q;
    exp_st_d     = exp_st_q;
    prev_st_d    = prev_st_q;
    exp_po_d     = exp_po_q;
    last_d       = last_q;
    po_d         = po_q;
    fail_d       = fail_q;
    fail_count_d = fail_count_q;
    vec_count_d  = vec_count_q;
    ffi_d        = ffi_q;
    load         = 1'b0;
    st_differs   = (captured != prev_st_q);
    mismatch     = vec_mismatch(first_vec_q, st_differs, po_q != exp_po_q);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d      = S_FETCH;
          fail_d       = 1'b0;
          fail_count_d = '0;
          vec_count_d  = '0;
          ffi_d        = '0;
          first_vec_d  = 1'b1;
          stop_mode_d  = stop_on_fail;
        end
      end
      S_FETCH: begin
        if (accept) begin
          load     = 1'b1;
          pi_d     = vec.vec_pi;
          exp_st_d = vec.vec_exp_st;
          exp_po_d = vec.vec_exp_po;
          last_d   = vec.vec_last;
          sc_d     = '0;
          state_d  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        sc_d = sc_q + 1'b1;
        if (sc_q == SC_LAST) begin
          sc_d    = '0;
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        po_d    = dut_po;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        vec_count_d = sat_inc(vec_count_q);
        if (mismatch) begin
          fail_d       = 1'b1;
          fail_count_d = sat_inc(fail_count_q);
          if (!fail_q) ffi_d = sat_inc(vec_count_q);
        end
        // The CUT now holds this vector's response; it is unloaded by the next shift.
        prev_st_d   = exp_st_q;
        first_vec_d = 1'b0;
        sc_d        = '0;
        if (mismatch && stop_mode_q) begin
          state_d = S_DONE;
        end else if (last_q) begin
          state_d = S_FLUSH;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_FLUSH: begin
        sc_d = sc_q + 1'b1;
        if (sc_q == SC_LAST) begin
          sc_d    = '0;
          state_d = S_FCHECK;
        end
      end
      S_FCHECK: begin
        if (st_differs) begin
          fail_d       = 1'b1;
          fail_count_d = sat_inc(fail_count_q);
          if (!fail_q) ffi_d = sat_inc(vec_count_q);
        end
        state_d = S_DONE;
      end
    endcase

    // Handshake and scan controls are registered from the next state.
    busy_d  = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d  = (state_d == S_DONE);
    ready_d = (state_d == S_FETCH);
    nbar_d  = (state_d != S_CAPTURE);
    si_en_d = (state_d == S_SHIFT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      sc_q         <= '0;
      stop_mode_q  <= 1'b0;
      first_vec_q  <= 1'b1;
      pi_q         <= '0;
      exp_st_q     <= '0;
      prev_st_q    <= '0;
      exp_po_q     <= '0;
      last_q       <= 1'b0;
      po_q         <= '0;
      fail_q       <= 1'b0;
      fail_count_q <= '0;
      vec_count_q  <= '0;
      ffi_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ready_q      <= 1'b0;
      nbar_q       <= 1'b1;
      si_en_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      sc_q         <= sc_d;
      stop_mode_q  <= stop_mode_d;
      first_vec_q  <= first_vec_d;
      pi_q         <= pi_d;
      exp_st_q     <= exp_st_d;
      prev_st_q    <= prev_st_d;
      exp_po_q     <= exp_po_d;
      last_q       <= last_d;
      po_q         <= po_d;
      fail_q       <= fail_d;
      fail_count_q <= fail_count_d;
      vec_count_q  <= vec_count_d;
      ffi_q        <= ffi_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      ready_q      <= ready_d;
      nbar_q       <= nbar_d;
      si_en_q      <= si_en_d;
    end
  end

  assign vec.vec_ready   = ready_q;
  assign dut_pi          = pi_q;
  assign dut_nbar_t      = nbar_q;
  assign dut_si          = chain_si & {NUM_CHAINS{si_en_q}};
  assign busy            = busy_q;
  assign done            = done_q;
  assign fail            = fail_q;
  assign fail_count      = fail_count_q;
  assign vec_count       = vec_count_q;
  assign first_fail_idx  = ffi_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_scan_test_ctrl.sv
// Bench for scan_test_ctrl with CHAIN_LEN=4, NUM_CHAINS=2 driving a small behavioural
// full-scan CUT; session outcomes come from a table, corner cases are hand-written.
module tb_scan_test_ctrl;
  import scan_test_pkg::*;

  localparam int CL = 4;
  localparam int NC = 2;
  localparam int SW = CL * NC;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          start;
  logic          stop_on_fail;
  logic [16:0]   dut_pi;
  logic          dut_nbar_t;
  logic [NC-1:0] dut_si;
  logic [NC-1:0] dut_so;
  logic [26:0]   dut_po;
  logic          busy, done, fail;
  logic [15:0]   fail_count, vec_count, first_fail_idx;
  state_t        dbg_state;

  scan_test_ctrl_if #(.PI_W(17), .ST_W(SW), .PO_W(27)) vif ();

  scan_test_ctrl #(
    .CHAIN_LEN(CL), .NUM_CHAINS(NC), .PI_W(17), .PO_W(27), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop_on_fail(stop_on_fail),
    .vec(vif),
    .dut_pi(dut_pi), .dut_nbar_t(dut_nbar_t), .dut_si(dut_si), .dut_so(dut_so),
    .dut_po(dut_po), .busy(busy), .done(done), .fail(fail),
    .fail_count(fail_count), .vec_count(vec_count), .first_fail_idx(first_fail_idx),
    .dbg_state(dbg_state)
  );

  // ---------------- behavioural CUT ----------------
  function automatic logic [7:0] cut_next(input logic [7:0] st, input logic [16:0] pi);
    return {st[6:0], st[7]} ^ pi[15:8] ^ {4'h0, pi[3:0]};
  endfunction

  function automatic logic [26:0] cut_po(input logic [7:0] st, input logic [16:0] pi);
    return {2'b01, st ^ pi[11:4], pi[16:1], pi[0]};
  endfunction

  logic [SW-1:0] cut_st = '0;
  logic          po_fault = 1'b0;
  logic          cut_shift_en;

  // The CUT's scan clock is gated to the sequencer's shift windows.
  assign cut_shift_en = dut_nbar_t && (dbg_state == S_SHIFT || dbg_state == S_FLUSH);

  always @(posedge clk) begin
    if (cut_shift_en) begin
      for (int c = 0; c < NC; c++)
        cut_st[c*CL +: CL] <= {dut_si[c], cut_st[c*CL+1 +: CL-1]};
    end else if (!dut_nbar_t) begin
      cut_st <= cut_next(cut_st, dut_pi);
    end
  end

  always_comb begin
    for (int c = 0; c < NC; c++) dut_so[c] = cut_st[c*CL];
    dut_po = cut_po(cut_st, dut_pi) | {26'b0, po_fault};
  end

  // ---------------- vector source ----------------
  typedef struct {
    logic [7:0]  scan;
    logic [16:0] pi;
  } vec_t;
  vec_t vt[3];

  int   src_idx = 0;
  logic src_en = 1'b0;
  logic src_hold = 1'b0;
  logic src_hs = 1'b0;
  logic bad_last_st = 1'b0;
  logic [1:0] sel;

  always_comb begin
    sel = 2'd2;
    if (src_idx < 3) sel = 2'(src_idx);
    vif.vec_valid  = src_en && !src_hold && (src_idx < 3);
    vif.vec_last   = (sel == 2'd2);
    vif.vec_pi     = vt[sel].pi;
    vif.vec_scan   = vt[sel].scan;
    vif.vec_exp_po = cut_po(vt[sel].scan, vt[sel].pi);
    vif.vec_exp_st = cut_next(vt[sel].scan, vt[sel].pi);
    if (bad_last_st && sel == 2'd2) vif.vec_exp_st = vif.vec_exp_st ^ 8'h20;
  end

  always @(negedge clk) src_hs = vif.vec_valid && vif.vec_ready;

  always @(posedge clk) begin
    if (src_hs) begin
      #1;
      src_idx = src_idx + 1;
    end
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_state"}, 32'(dbg_state), 32'(S_IDLE));
    chk({tag, "_nbar_t"}, 32'(dut_nbar_t), 32'd1);
    chk({tag, "_si"}, 32'(dut_si), 32'd0);
    chk({tag, "_pi"}, 32'(dut_pi), 32'd0);
    chk({tag, "_ready"}, 32'(vif.vec_ready), 32'd0);
    chk({tag, "_busy_done_fail"}, {29'd0, busy, done, fail}, 32'd0);
    chk({tag, "_counts"}, {fail_count, vec_count}, 32'd0);
    chk({tag, "_ffi"}, 32'(first_fail_idx), 32'd0);
  endtask

  task automatic kick(input logic sof);
    src_idx      = 0;
    src_en       = 1'b1;
    stop_on_fail = sof;
    start        = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int cycles, output logic flushed);
    cycles  = 0;
    flushed = 1'b0;
    while (!done && cycles < 500) begin
      @(posedge clk); #1;
      cycles++;
      if (dbg_state == S_FLUSH) flushed = 1'b1;
    end
    chk({tag, "_done_reached"}, 32'(done), 32'd1);
    src_en = 1'b0;
  endtask

  // ---------------- session table ----------------
  typedef struct {
    logic sof;
    logic po_flt;
    logic bad_st;
    int   exp_vc;
    logic exp_fail;
    int   exp_fc;
    int   exp_ffi;
    logic exp_flush;
  } sess_t;
  sess_t tbl[6];

  int   cyc;
  logic fl;

  initial begin
    vt[0] = '{scan: 8'hA5, pi: 17'h0_1235};
    vt[1] = '{scan: 8'h3C, pi: 17'h1_4C6A};
    vt[2] = '{scan: 8'hF0, pi: 17'h0_9E0F};

    //          sof  pofl bst  vc  fail fc ffi flush
    tbl[0] = '{1'b0, 1'b0, 1'b0, 3, 1'b0, 0, 0, 1'b1};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 3, 1'b1, 1, 2, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 2, 1'b1, 1, 2, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 3, 1'b1, 1, 4, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 3, 1'b1, 2, 2, 1'b1};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 3, 1'b0, 0, 0, 1'b1};

    rst = 1'b1;
    start = 1'b0;
    stop_on_fail = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Nominal session with vec_valid held: 3*7 + 4 flush + 1 fcheck edges to DONE.
    kick(1'b0);
    wait_done("latency", cyc, fl);
    chk("latency_cycles", 32'(cyc), 32'd26);
    chk("latency_vec_count", 32'(vec_count), 32'd3);
    chk("latency_fail", 32'(fail), 32'd0);

    for (int i = 0; i < 6; i++) begin
      po_fault    = tbl[i].po_flt;
      bad_last_st = tbl[i].bad_st;
      kick(tbl[i].sof);
      wait_done($sformatf("sess%0d", i), cyc, fl);
      chk($sformatf("sess%0d_vec_count", i), 32'(vec_count), 32'(tbl[i].exp_vc));
      chk($sformatf("sess%0d_fail", i), 32'(fail), 32'(tbl[i].exp_fail));
      chk($sformatf("sess%0d_fail_count", i), 32'(fail_count), 32'(tbl[i].exp_fc));
      chk($sformatf("sess%0d_first_fail_idx", i), 32'(first_fail_idx), 32'(tbl[i].exp_ffi));
      chk($sformatf("sess%0d_flushed", i), 32'(fl), 32'(tbl[i].exp_flush));
      chk($sformatf("sess%0d_idle_ctl", i), {29'd0, busy, dut_nbar_t, vif.vec_ready}, 32'b010);
    end
    po_fault    = 1'b0;
    bad_last_st = 1'b0;

    // FETCH stall: source withholds vector 2 for 10 cycles.
    kick(1'b0);
    cyc = 0;
    while (src_idx < 1 && cyc < 50) begin @(posedge clk); #1; cyc++; end
    chk("stall_v1_accepted", 32'(src_idx), 32'd1);
    src_hold = 1'b1;
    cyc = 0;
    while (dbg_state != S_FETCH && cyc < 50) begin @(posedge clk); #1; cyc++; end
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk($sformatf("stall_c%0d", k),
          {27'd0, vif.vec_ready, dut_nbar_t, busy, dbg_state == S_FETCH, dut_si == 2'b00},
          32'b11111);
    end
    src_hold = 1'b0;
    wait_done("stall", cyc, fl);
    chk("stall_vec_count", 32'(vec_count), 32'd3);
    chk("stall_fail_count", {16'd0, fail_count}, 32'd0);
    chk("stall_fail", 32'(fail), 32'd0);

    // Reset in the middle of vector 2's shift, then a clean rerun.
    kick(1'b0);
    cyc = 0;
    while (src_idx < 2 && cyc < 50) begin @(posedge clk); #1; cyc++; end
    chk("rstmid_in_shift", 32'(dbg_state), 32'(S_SHIFT));
    @(posedge clk); #1;
    src_en = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset("rstmid");
    rst = 1'b0;
    @(posedge clk); #1;
    kick(1'b0);
    wait_done("rerun", cyc, fl);
    chk("rerun_cycles", 32'(cyc), 32'd26);
    chk("rerun_vec_count", 32'(vec_count), 32'd3);
    chk("rerun_fail_count", {16'd0, fail_count}, 32'd0);
    chk("rerun_fail", 32'(fail), 32'd0);

    // start while busy is ignored: session result unchanged.
    kick(1'b0);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("busy_start", cyc, fl);
    chk("busy_start_vec_count", 32'(vec_count), 32'd3);
    chk("busy_start_fail", 32'(fail), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
